// File: rtl/gpio_in_cond_pkg.sv
// Shared GPIO constants and the per-bit event record handed to the
// register/interrupt block.
package gpio_in_cond_pkg;

  localparam int unsigned GPIO_WIDTH       = 32;
  localparam int unsigned GPIO_FILT_CNT_W  = 4;
  localparam int unsigned GPIO_SYNC_STAGES = 2;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } gpio_in_evt_t;

endpackage

// File: rtl/gpio_in_cond_bit.sv
// Single-bit conditioning: synchroniser, optional stability filter and
// registered rise/fall event pulses.
module gpio_in_cond_bit
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned CntWidth   = GPIO_FILT_CNT_W,
  parameter int unsigned SyncStages = GPIO_SYNC_STAGES
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                gpio_i,
  input  logic                filter_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic                sync_o,
  output gpio_in_evt_t        evt_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  sync;
  logic                  prev_q;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  stored_q, stored_d;
  logic                  rise_q, fall_q;

  assign sync = sync_q[SyncStages-1];

  always_comb begin
    cnt_d    = '0;
    stored_d = sync;
    if (filter_en_i) begin
      // cnt_q counts consecutive samples where the level matched prev_q;
      // once it reaches the threshold prev_q is trusted as the new level.
      if (sync != prev_q) begin
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CntWidth'(1);
      end else begin
        cnt_d = cnt_q;
      end
      stored_d = (cnt_q >= thresh_i) ? prev_q : stored_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      stored_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SyncStages-2:0], gpio_i};
      prev_q   <= sync;
      cnt_q    <= cnt_d;
      stored_q <= stored_d;
      rise_q   <= ~stored_q & stored_d;
      fall_q   <= stored_q & ~stored_d;
    end
  end

  assign sync_o      = sync;
  assign evt_o.level = stored_q;
  assign evt_o.rise  = rise_q;
  assign evt_o.fall  = fall_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: one independent conditioning slice per pad bit,
// sharing only the stability threshold.
module gpio_in_cond
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned Width      = GPIO_WIDTH,
  parameter int unsigned CntWidth   = GPIO_FILT_CNT_W,
  parameter int unsigned SyncStages = GPIO_SYNC_STAGES
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Width-1:0]    gpio_i,
  input  logic [Width-1:0]    filter_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic [Width-1:0]    gpio_sync_o,
  output logic [Width-1:0]    gpio_filt_o,
  output logic [Width-1:0]    rise_o,
  output logic [Width-1:0]    fall_o
);

  gpio_in_evt_t evt [Width];

  for (genvar i = 0; i < int'(Width); i++) begin : g_bit
    gpio_in_cond_bit #(
      .CntWidth   (CntWidth),
      .SyncStages (SyncStages)
    ) u_bit (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .gpio_i      (gpio_i[i]),
      .filter_en_i (filter_en_i[i]),
      .thresh_i    (thresh_i),
      .sync_o      (gpio_sync_o[i]),
      .evt_o       (evt[i])
    );

    assign gpio_filt_o[i] = evt[i].level;
    assign rise_o[i]      = evt[i].rise;
    assign fall_o[i]      = evt[i].fall;
  end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: directed vector tables, pulse sequences and a
// randomized run scored against a history-based reference model.
module tb_gpio_in_cond;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gpio = '0;
  logic [31:0] en = '0;
  logic [3:0]  thr = 4'd3;
  logic [31:0] dut_sync, dut_filt, dut_rise, dut_fall;

  always #5 clk = ~clk;

  gpio_in_cond #(.Width(32), .CntWidth(4), .SyncStages(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .gpio_i      (gpio),
    .filter_en_i (en),
    .thresh_i    (thr),
    .gpio_sync_o (dut_sync),
    .gpio_filt_o (dut_filt),
    .rise_o      (dut_rise),
    .fall_o      (dut_fall)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remembers every sampled pad vector and enable vector
  // since reset, and decides the filtered level from how long the
  // synchronised value has been stable (a level is accepted once it has been
  // seen unchanged on thresh+1 consecutive enabled samples).
  logic [31:0] g_h  [16384];
  logic [31:0] en_h [16384];
  int          e    = 0;
  int          base = 1;
  logic [31:0] m_sync = '0, m_filt = '0, m_rise = '0, m_fall = '0;

  function automatic logic [31:0] gv(int idx);
    if (idx < base) return '0;
    return g_h[idx];
  endfunction

  function automatic int stable_run(int ne, int b);
    int c;
    logic [31:0] a, p;
    c = 0;
    for (int j = ne - 1; j >= base && c < 15; j--) begin
      a = gv(j - 2);
      p = gv(j - 3);
      if (en_h[j][b] && (a[b] == p[b])) c++;
      else break;
    end
    return c;
  endfunction

  function automatic logic [31:0] next_filt(int ne);
    logic [31:0] nf, s, p;
    nf = m_filt;
    s  = gv(ne - 2);
    p  = gv(ne - 3);
    for (int b = 0; b < 32; b++) begin
      if (!en[b]) nf[b] = s[b];
      else if (stable_run(ne, b) >= int'(thr)) nf[b] = p[b];
    end
    return nf;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync <= '0;
      m_filt <= '0;
      m_rise <= '0;
      m_fall <= '0;
      base   <= e + 1;
    end else begin
      m_sync    <= gv(e);
      m_filt    <= next_filt(e + 1);
      m_rise    <= ~m_filt & next_filt(e + 1);
      m_fall    <= m_filt & ~next_filt(e + 1);
      g_h[e+1]  <= gpio;
      en_h[e+1] <= en;
      e         <= e + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("sync",      dut_sync, m_sync);
    chk("filt",      dut_filt, m_filt);
    chk("rise",      dut_rise, m_rise);
    chk("fall",      dut_fall, m_fall);
    chk("rise&fall", dut_rise & dut_fall, '0);
  endtask

  typedef struct {
    logic g;
    logic s;
    logic f;
    logic r;
    logic fl;
  } vec_t;

  vec_t tbl_b0 [$];
  vec_t tbl_b9 [$];

  int rem [32];
  int hi_n, r_n, f_n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Bit 0, filtered, thresh 3: row k is the input before edge k and the
    // outputs seen after edge k.
    for (int k = 1; k <= 9; k++)
      tbl_b0.push_back('{g: 1'b1, s: (k >= 2), f: (k >= 7), r: (k == 7), fl: 1'b0});
    // Bit 9, unfiltered, one-cycle pulse.
    for (int k = 1; k <= 6; k++)
      tbl_b9.push_back('{g: (k == 1), s: (k == 2), f: (k == 3), r: (k == 3), fl: (k == 4)});

    en = 32'h0000_0025;
    repeat (3) tick();
    chk("reset_filt", dut_filt, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_filt", dut_filt, '0);
      chk("idle_pulses", dut_rise | dut_fall, '0);
    end

    foreach (tbl_b0[i]) begin
      gpio[0] = tbl_b0[i].g;
      tick();
      chk("b0_sync", {31'b0, dut_sync[0]}, {31'b0, tbl_b0[i].s});
      chk("b0_filt", {31'b0, dut_filt[0]}, {31'b0, tbl_b0[i].f});
      chk("b0_rise", {31'b0, dut_rise[0]}, {31'b0, tbl_b0[i].r});
      chk("b0_fall", {31'b0, dut_fall[0]}, {31'b0, tbl_b0[i].fl});
    end

    // Bit 5: a 3-cycle pulse is swallowed, a 4-cycle pulse passes intact.
    for (int w = 3; w <= 4; w++) begin
      hi_n = 0; r_n = 0; f_n = 0;
      for (int i = 0; i < 20; i++) begin
        gpio[5] = (i < w);
        tick();
        hi_n += int'(dut_filt[5]);
        r_n  += int'(dut_rise[5]);
        f_n  += int'(dut_fall[5]);
      end
      chk("b5_hi_cycles", hi_n, (w == 4) ? 4 : 0);
      chk("b5_rises",     r_n,  (w == 4) ? 1 : 0);
      chk("b5_falls",     f_n,  (w == 4) ? 1 : 0);
    end

    foreach (tbl_b9[i]) begin
      gpio[9] = tbl_b9[i].g;
      tick();
      chk("b9_sync", {31'b0, dut_sync[9]}, {31'b0, tbl_b9[i].s});
      chk("b9_filt", {31'b0, dut_filt[9]}, {31'b0, tbl_b9[i].f});
      chk("b9_rise", {31'b0, dut_rise[9]}, {31'b0, tbl_b9[i].r});
      chk("b9_fall", {31'b0, dut_fall[9]}, {31'b0, tbl_b9[i].fl});
    end

    // Bit 2: lowering the threshold below the running count releases the
    // level on the very next edge; then a long hold yields no more edges.
    thr = 4'd15;
    gpio[2] = 1'b1;
    repeat (11) tick();
    chk("b2_held_back", {31'b0, dut_filt[2]}, 32'd0);
    thr = 4'd4;
    tick();
    chk("b2_released", {31'b0, dut_filt[2]}, 32'd1);
    chk("b2_rise", {31'b0, dut_rise[2]}, 32'd1);
    r_n = 0; f_n = 0; hi_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      r_n  += int'(dut_rise[2]);
      f_n  += int'(dut_fall[2]);
      hi_n += int'(dut_filt[2]);
    end
    chk("b2_hold_edges", r_n + f_n, 0);
    chk("b2_hold_level", hi_n, 40);

    // Randomized run across all bits.
    for (int b = 0; b < 32; b++) rem[b] = $urandom_range(1, 20);
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) thr = 4'($urandom_range(0, 15));
      if (c % 250 == 0) en = $urandom;
      for (int b = 0; b < 32; b++) begin
        if (rem[b] == 0) begin
          gpio[b] = ~gpio[b];
          rem[b]  = $urandom_range(1, 20);
        end else begin
          rem[b]--;
        end
      end
      if (c == 777) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sync", dut_sync, '0);
        chk("async_rst_filt", dut_filt, '0);
        chk("async_rst_rise", dut_rise, '0);
        chk("async_rst_fall", dut_fall, '0);
        repeat (3) tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
